// File: rtl/snes_csync_gen.sv
// snes_csync_gen: SNES-style composite sync generator with H/V counters,
// field parity and an optional shortened line in field 1.
module snes_csync_gen #(
    parameter int H_TOTAL      = 1364,
    parameter int H_SHORT      = 1360,
    parameter int HS_LEN       = 100,
    parameter int V_TOTAL      = 262,
    parameter int V_SHORT_LINE = 240,
    parameter int VS_START     = 232,
    parameter int VS_LEN       = 3
) (
    input  logic        MCLK_i,
    input  logic        RESET_N_i,
    input  logic        ENABLE_i,
    input  logic        SHORT_EN_i,
    output logic        CSYNC_o,
    output logic [10:0] H_CNT_o,
    output logic [8:0]  V_CNT_o,
    output logic        FIELD_o,
    output logic        LINE_END_o,
    output logic        SHORT_LINE_o
);
    logic [10:0] h_q, h_d, len;
    logic [8:0]  v_q, v_d;
    logic        field_q, field_d, short_en_q, short_en_d, csync_q, csync_d;
    logic        short_line, line_end, frame_end, vs;

    assign short_line = short_en_q & field_q & (v_q == 9'(V_SHORT_LINE));
    assign len        = short_line ? 11'(H_SHORT) : 11'(H_TOTAL);
    assign line_end   = h_q == len - 11'd1;
    assign frame_end  = line_end & (v_q == 9'(V_TOTAL - 1));
    assign vs         = (v_q >= 9'(VS_START)) && (v_q < 9'(VS_START + VS_LEN));

    // Sync level is derived from the pre-advance position, so it trails the counters by one cycle.
    always_comb begin
        h_d        = line_end ? 11'd0 : h_q + 11'd1;
        v_d        = line_end ? (frame_end ? 9'd0 : v_q + 9'd1) : v_q;
        field_d    = field_q ^ frame_end;
        short_en_d = frame_end ? SHORT_EN_i : short_en_q;
        csync_d    = vs ? (h_q >= len - 11'(HS_LEN)) : (h_q >= 11'(HS_LEN));
    end

    always_ff @(posedge MCLK_i or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            h_q        <= '0;
            v_q        <= '0;
            field_q    <= 1'b0;
            short_en_q <= 1'b0;
            csync_q    <= 1'b1;
        end else if (ENABLE_i) begin
            h_q        <= h_d;
            v_q        <= v_d;
            field_q    <= field_d;
            short_en_q <= short_en_d;
            csync_q    <= csync_d;
        end
    end

    assign CSYNC_o      = csync_q;
    assign H_CNT_o      = h_q;
    assign V_CNT_o      = v_q;
    assign FIELD_o      = field_q;
    assign LINE_END_o   = line_end;
    assign SHORT_LINE_o = short_line;
endmodule

// File: tb/tb_snes_csync_gen.sv
// tb_snes_csync_gen: default-size instance checked against a vector table,
// reduced-size instance checked cycle by cycle against a behavioural model.
module tb_snes_csync_gen;
    localparam int SHT = 40, SHS = 36, SHL = 5, SVT = 12, SVSL = 8, SVS = 6, SVL = 3;

    logic        clk = 1'b0;
    logic        d_rst_n, d_en, d_se, d_cs, d_f, d_le, d_sl;
    logic [10:0] d_h;
    logic [8:0]  d_v;
    logic        s_rst_n, s_en, s_se, s_cs, s_f, s_le, s_sl;
    logic [10:0] s_h;
    logic [8:0]  s_v;

    int checks = 0, errors = 0;
    int mh, mv, mf, mse, mcs;

    typedef struct {int cyc; int cs; int le; int h; int v;} vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    snes_csync_gen dut_d (
        .MCLK_i(clk), .RESET_N_i(d_rst_n), .ENABLE_i(d_en), .SHORT_EN_i(d_se),
        .CSYNC_o(d_cs), .H_CNT_o(d_h), .V_CNT_o(d_v), .FIELD_o(d_f),
        .LINE_END_o(d_le), .SHORT_LINE_o(d_sl)
    );

    snes_csync_gen #(
        .H_TOTAL(SHT), .H_SHORT(SHS), .HS_LEN(SHL), .V_TOTAL(SVT),
        .V_SHORT_LINE(SVSL), .VS_START(SVS), .VS_LEN(SVL)
    ) dut_s (
        .MCLK_i(clk), .RESET_N_i(s_rst_n), .ENABLE_i(s_en), .SHORT_EN_i(s_se),
        .CSYNC_o(s_cs), .H_CNT_o(s_h), .V_CNT_o(s_v), .FIELD_o(s_f),
        .LINE_END_o(s_le), .SHORT_LINE_o(s_sl)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int m_len();
        return (mse != 0 && mf != 0 && mv == SVSL) ? SHS : SHT;
    endfunction

    // Reference: line length, sync window and field rules in plain integer arithmetic.
    task automatic m_step();
        int len = m_len();
        bit vs = mv >= SVS && mv < SVS + SVL;
        mcs = vs ? int'(mh >= len - SHL) : int'(mh >= SHL);
        if (mh == len - 1) begin
            mh = 0;
            if (mv == SVT - 1) begin
                mv = 0;
                mf ^= 1;
                mse = int'(s_se);
            end else mv++;
        end else mh++;
    endtask

    task automatic s_cmp();
        chk("s_h", int'(s_h), mh);
        chk("s_v", int'(s_v), mv);
        chk("s_field", int'(s_f), mf);
        chk("s_csync", int'(s_cs), mcs);
        chk("s_line_end", int'(s_le), int'(mh == m_len() - 1));
        chk("s_short_line", int'(s_sl), int'(m_len() == SHS));
    endtask

    task automatic s_cycle();
        @(posedge clk);
        if (s_rst_n && s_en) m_step();
        #1;
        s_cmp();
    endtask

    task automatic s_reset();
        s_rst_n = 1'b0;
        mh = 0; mv = 0; mf = 0; mse = 0; mcs = 1;
        #1;
        s_cmp();
        @(negedge clk);
        s_rst_n = 1'b1;
    endtask

    task automatic d_reset();
        d_rst_n = 1'b0;
        #1;
        chk("d_rst_h", int'(d_h), 0);
        chk("d_rst_v", int'(d_v), 0);
        chk("d_rst_field", int'(d_f), 0);
        chk("d_rst_csync", int'(d_cs), 1);
        chk("d_rst_line_end", int'(d_le), 0);
        chk("d_rst_short", int'(d_sl), 0);
        @(negedge clk);
        d_rst_n = 1'b1;
    endtask

    task automatic run_tbl();
        d_en = 1'b1;
        for (int c = 1; c <= 1365; c++) begin
            @(posedge clk);
            #1;
            foreach (tbl[i]) if (tbl[i].cyc == c) begin
                chk($sformatf("tbl%0d_csync", c), int'(d_cs), tbl[i].cs);
                chk($sformatf("tbl%0d_line_end", c), int'(d_le), tbl[i].le);
                chk($sformatf("tbl%0d_h", c), int'(d_h), tbl[i].h);
                chk($sformatf("tbl%0d_v", c), int'(d_v), tbl[i].v);
            end
        end
    endtask

    initial begin
        int n, sl, le_h;
        int lows[SVT];
        tbl[0] = '{1, 0, 0, 1, 0};
        tbl[1] = '{50, 0, 0, 50, 0};
        tbl[2] = '{100, 0, 0, 100, 0};
        tbl[3] = '{101, 1, 0, 101, 0};
        tbl[4] = '{1362, 1, 0, 1362, 0};
        tbl[5] = '{1363, 1, 1, 1363, 0};
        tbl[6] = '{1364, 1, 0, 0, 1};
        tbl[7] = '{1365, 0, 0, 1, 1};
        d_rst_n = 1'b1; d_en = 1'b0; d_se = 1'b0;
        s_rst_n = 1'b1; s_en = 1'b0; s_se = 1'b0;
        #2;
        d_reset();
        run_tbl();
        n = 0;
        while (d_h != 11'd700 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("d_reach_h700", int'(d_h), 700);
        #1;
        d_reset();
        run_tbl();
        // Freeze at position 99, then resume and watch the sync edge.
        #1;
        d_en = 1'b0;
        d_reset();
        d_en = 1'b1;
        repeat (99) @(posedge clk);
        #1;
        d_en = 1'b0;
        chk("frz_pre_h", int'(d_h), 99);
        repeat (50) @(posedge clk);
        #1;
        chk("frz_h", int'(d_h), 99);
        chk("frz_csync", int'(d_cs), 0);
        chk("frz_v", int'(d_v), 0);
        chk("frz_line_end", int'(d_le), 0);
        d_en = 1'b1;
        @(posedge clk); #1;
        chk("res1_h", int'(d_h), 100);
        chk("res1_csync", int'(d_cs), 0);
        @(posedge clk); #1;
        chk("res2_csync", int'(d_cs), 1);
        d_en = 1'b0;
        // Vsync serration widths over one field-0 frame.
        s_reset();
        s_en = 1'b1; s_se = 1'b0;
        foreach (lows[i]) lows[i] = 0;
        repeat (SVT * SHT) begin
            s_cycle();
            if (!s_cs) lows[s_v]++;
        end
        for (int l = SVS - 1; l <= SVS + SVL; l++)
            chk($sformatf("lows_line%0d", l), lows[l], (l >= SVS && l < SVS + SVL) ? SHT - SHL : SHL);
        // Short line enabled across the wrap into field 1.
        s_reset();
        s_se = 1'b1;
        n = 0;
        do begin s_cycle(); n++; end while (s_f == 1'b0 && n < 1000);
        chk("field0_len", n, SVT * SHT);
        n = 0; sl = 0; le_h = -1;
        do begin
            s_cycle(); n++;
            if (s_sl) sl++;
            if (s_sl && s_le) le_h = int'(s_h);
        end while (s_f == 1'b1 && n < 1000);
        chk("field1_len", n, SVT * SHT - (SHT - SHS));
        chk("field1_short_cycles", sl, SHS);
        chk("short_line_end_h", le_h, SHS - 1);
        // One-cycle drop of SHORT_EN exactly at the wrap suppresses the short line.
        s_reset();
        s_se = 1'b1;
        n = 0;
        while (!(s_v == 9'(SVT - 1) && s_h == 11'(SHT - 1)) && n < 1000) begin s_cycle(); n++; end
        s_se = 1'b0;
        s_cycle();
        s_se = 1'b1;
        chk("drop_field", int'(s_f), 1);
        n = 0; sl = 0;
        do begin s_cycle(); n++; if (s_sl) sl++; end while (s_f == 1'b1 && n < 1000);
        chk("drop_short_cycles", sl, 0);
        chk("drop_field1_len", n, SVT * SHT);
        // Random enable, short-enable and asynchronous resets against the model.
        for (int i = 0; i < 15000; i++) begin
            s_en = ($urandom % 8) != 0;
            s_se = 1'($urandom % 2);
            s_cycle();
            if ($urandom % 2000 == 0) begin #2; s_reset(); end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
